edge_detector_mc: RTL and testbench

Parametrised multi-channel edge detector for the TDC front end. Each of NCH asynchronous hit lines is synchronised and optionally glitch-filtered, then produces rise/fall pulses. A run-time edge-mode select gates these into events. Per-channel saturating event counters and a coarse timestamp capture with a valid/ack handshake sit behind the detector. It replaces the single-channel rise/fall detector and feeds the coarse-time and readout logic.

---
 rtl/edge_detector_mc.sv | 147 ++++++++++++++
 tb/tb_edge_detector_mc.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_detector_mc.sv
// Multi-channel hit edge detector: synchroniser, glitch filter, rise/fall pulses,
// mode-gated events, saturating per-channel counters and a coarse-time capture with ack.
module edge_detector_mc #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TS_W        = 16
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic [NCH-1:0]       iHit,
  input  logic [1:0]           iMode,
  input  logic                 iClear,
  input  logic                 iAck,
  output logic [NCH-1:0]       oRise,
  output logic [NCH-1:0]       oFall,
  output logic [NCH-1:0]       oEvent,
  output logic [NCH*CNT_W-1:0] oCount,
  output logic                 oStampValid,
  output logic [TS_W-1:0]      oStamp,
  output logic [NCH-1:0]       oStampMask,
  output logic                 oOverflow
);

  localparam int unsigned WARM   = SYNC_STAGES + FILT_LEN;
  localparam int unsigned WARM_W = $clog2(WARM + 1);
  localparam int unsigned FCNT_W = $clog2(FILT_LEN + 1);

  logic [SYNC_STAGES-1:0][NCH-1:0] r_sync;
  logic [WARM_W-1:0]               r_warm;
  logic [NCH-1:0]                  r_flt;
  logic [NCH-1:0]                  r_flt_d;
  logic [FCNT_W-1:0]               r_fcnt [NCH];
  logic [NCH-1:0]                  r_rise;
  logic [NCH-1:0]                  r_fall;
  logic [NCH-1:0][CNT_W-1:0]       r_count;
  logic [TS_W-1:0]                 r_ts;
  logic                            r_valid;
  logic [TS_W-1:0]                 r_stamp;
  logic [NCH-1:0]                  r_mask;
  logic                            r_ovf;

  logic [NCH-1:0] w_lvl;
  logic           w_warm_done;
  logic [NCH-1:0] w_event;
  logic           w_any_ev;

  assign w_lvl       = r_sync[SYNC_STAGES-1];
  assign w_warm_done = (r_warm == WARM_W'(WARM));
  assign w_event     = (r_rise & {NCH{iMode[0]}}) | (r_fall & {NCH{iMode[1]}});
  assign w_any_ev    = |w_event;

  // Synchroniser chain and warm-up counter
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_sync <= '0;
      r_warm <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], iHit};
      if (!w_warm_done) r_warm <= r_warm + WARM_W'(1);
    end
  end

  // Filter: during warm-up track the line directly so a static level gives no edge
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_flt   <= '0;
      r_flt_d <= '0;
      for (int unsigned i = 0; i < NCH; i++) r_fcnt[i] <= '0;
    end else if (!w_warm_done) begin
      r_flt   <= w_lvl;
      r_flt_d <= w_lvl;
      for (int unsigned i = 0; i < NCH; i++) r_fcnt[i] <= '0;
    end else begin
      r_flt_d <= r_flt;
      for (int unsigned i = 0; i < NCH; i++) begin
        if (w_lvl[i] != r_flt[i]) begin
          if (r_fcnt[i] == FCNT_W'(FILT_LEN - 1)) begin
            r_flt[i]  <= w_lvl[i];
            r_fcnt[i] <= '0;
          end else begin
            r_fcnt[i] <= r_fcnt[i] + FCNT_W'(1);
          end
        end else begin
          r_fcnt[i] <= '0;
        end
      end
    end
  end

  // Registered edge pulses
  always_ff @(posedge iClk) begin
    if (iRst || !w_warm_done) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= r_flt & ~r_flt_d;
      r_fall <= ~r_flt & r_flt_d;
    end
  end

  // Saturating event counters; clear wins over increment
  always_ff @(posedge iClk) begin
    if (iRst || iClear) begin
      r_count <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++)
        if (w_event[i] && (r_count[i] != {CNT_W{1'b1}})) r_count[i] <= r_count[i] + CNT_W'(1);
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) r_ts <= '0;
    else      r_ts <= r_ts + TS_W'(1);
  end

  // Stamp capture/hold; an ack frees the slot for an event in the same cycle
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_valid <= 1'b0;
      r_stamp <= '0;
      r_mask  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_any_ev && (!r_valid || iAck)) begin
        r_valid <= 1'b1;
        r_stamp <= r_ts;
        r_mask  <= w_event;
      end else if (r_valid && iAck) begin
        r_valid <= 1'b0;
      end
      if (iClear)                              r_ovf <= 1'b0;
      else if (w_any_ev && r_valid && !iAck)   r_ovf <= 1'b1;
    end
  end

  assign oRise       = r_rise;
  assign oFall       = r_fall;
  assign oEvent      = w_event;
  assign oCount      = r_count;
  assign oStampValid = r_valid;
  assign oStamp      = r_stamp;
  assign oStampMask  = r_mask;
  assign oOverflow   = r_ovf;

endmodule

// File: tb/tb_edge_detector_mc.sv
// Directed bench for edge_detector_mc: per-cycle vector table plus hand-timed
// sequences for glitches, overflow, saturation and timestamp wrap.
module tb_edge_detector_mc;

  logic        iClk = 1'b0;
  logic        iRst;
  logic [3:0]  iHit;
  logic [1:0]  iMode;
  logic        iClear;
  logic        iAck;
  logic [3:0]  oRise, oFall, oEvent, oStampMask;
  logic [31:0] oCount;
  logic        oStampValid, oOverflow;
  logic [15:0] oStamp;

  edge_detector_mc dut (
    .iClk(iClk), .iRst(iRst), .iHit(iHit), .iMode(iMode), .iClear(iClear), .iAck(iAck),
    .oRise(oRise), .oFall(oFall), .oEvent(oEvent), .oCount(oCount),
    .oStampValid(oStampValid), .oStamp(oStamp), .oStampMask(oStampMask), .oOverflow(oOverflow)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [3:0]  hit;
    logic [1:0]  mode;
    logic        clr;
    logic        ack;
    logic [3:0]  e_rise;
    logic [3:0]  e_fall;
    logic [3:0]  e_ev;
    logic        e_val;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t        tbl [35];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] ts = 16'd0;
  int          tnum = 0;
  int          rise_seen [4];
  int          fall_seen [4];
  int          ev_seen = 0;
  int          rise_t, fall_t;
  logic [15:0] exp_stamp, s1, s2;
  logic [3:0]  exp_mask;

  function automatic vec_t mk(input logic [3:0] hit, input logic [1:0] mode, input logic clr,
                              input logic ack, input logic [3:0] er, input logic [3:0] ef,
                              input logic [3:0] ee, input logic ev, input logic [31:0] ec);
    vec_t v;
    v.hit = hit; v.mode = mode; v.clr = clr; v.ack = ack;
    v.e_rise = er; v.e_fall = ef; v.e_ev = ee; v.e_val = ev; v.e_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_seen();
    for (int c = 0; c < 4; c++) begin rise_seen[c] = 0; fall_seen[c] = 0; end
    ev_seen = 0;
    rise_t  = -1;
    fall_t  = -1;
  endtask

  // One clock: advance the reference timestamp, then observe outputs 1 unit later
  task automatic tick();
    @(posedge iClk);
    ts = iRst ? 16'd0 : ts + 16'd1;
    #1;
    tnum++;
    for (int c = 0; c < 4; c++) begin
      if (oRise[c]) rise_seen[c]++;
      if (oFall[c]) fall_seen[c]++;
    end
    if (oEvent != 4'b0) ev_seen++;
    if (oRise[2]) rise_t = tnum;
    if (oFall[2]) fall_t = tnum;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // hit, mode, clr, ack, rise, fall, event, valid, counts
    tbl[0]  = mk(4'h1, 2'b01, 0, 0, 4'h0, 4'h0, 4'h0, 0, 32'h000);
    tbl[1]  = mk(4'h1, 2'b01, 0, 0, 4'h0, 4'h0, 4'h0, 0, 32'h000);
    tbl[2]  = mk(4'h1, 2'b01, 0, 0, 4'h0, 4'h0, 4'h0, 0, 32'h000);
    tbl[3]  = mk(4'h1, 2'b01, 0, 0, 4'h0, 4'h0, 4'h0, 0, 32'h000);
    tbl[4]  = mk(4'h1, 2'b01, 0, 0, 4'h1, 4'h0, 4'h1, 0, 32'h000);
    tbl[5]  = mk(4'h1, 2'b01, 0, 0, 4'h0, 4'h0, 4'h0, 1, 32'h001);
    tbl[6]  = mk(4'h1, 2'b01, 0, 1, 4'h0, 4'h0, 4'h0, 0, 32'h001);
    tbl[7]  = mk(4'h1, 2'b01, 0, 0, 4'h0, 4'h0, 4'h0, 0, 32'h001);
    tbl[8]  = mk(4'h3, 2'b10, 0, 0, 4'h0, 4'h0, 4'h0, 0, 32'h001);
    tbl[9]  = mk(4'h3, 2'b10, 0, 0, 4'h0, 4'h0, 4'h0, 0, 32'h001);
    tbl[10] = mk(4'h3, 2'b10, 0, 0, 4'h0, 4'h0, 4'h0, 0, 32'h001);
    tbl[11] = mk(4'h3, 2'b10, 0, 0, 4'h0, 4'h0, 4'h0, 0, 32'h001);
    tbl[12] = mk(4'h3, 2'b10, 0, 0, 4'h2, 4'h0, 4'h0, 0, 32'h001);
    tbl[13] = mk(4'h3, 2'b10, 0, 0, 4'h0, 4'h0, 4'h0, 0, 32'h001);
    tbl[14] = mk(4'h1, 2'b10, 0, 0, 4'h0, 4'h0, 4'h0, 0, 32'h001);
    tbl[15] = mk(4'h1, 2'b10, 0, 0, 4'h0, 4'h0, 4'h0, 0, 32'h001);
    tbl[16] = mk(4'h1, 2'b10, 0, 0, 4'h0, 4'h0, 4'h0, 0, 32'h001);
    tbl[17] = mk(4'h1, 2'b10, 0, 0, 4'h0, 4'h0, 4'h0, 0, 32'h001);
    tbl[18] = mk(4'h1, 2'b10, 0, 0, 4'h0, 4'h2, 4'h2, 0, 32'h001);
    tbl[19] = mk(4'h1, 2'b10, 0, 0, 4'h0, 4'h0, 4'h0, 1, 32'h101);
    tbl[20] = mk(4'h1, 2'b10, 0, 1, 4'h0, 4'h0, 4'h0, 0, 32'h101);
    tbl[21] = mk(4'h1, 2'b11, 1, 0, 4'h0, 4'h0, 4'h0, 0, 32'h000);
    tbl[22] = mk(4'h3, 2'b11, 0, 0, 4'h0, 4'h0, 4'h0, 0, 32'h000);
    tbl[23] = mk(4'h3, 2'b11, 0, 0, 4'h0, 4'h0, 4'h0, 0, 32'h000);
    tbl[24] = mk(4'h3, 2'b11, 0, 0, 4'h0, 4'h0, 4'h0, 0, 32'h000);
    tbl[25] = mk(4'h3, 2'b11, 0, 0, 4'h0, 4'h0, 4'h0, 0, 32'h000);
    tbl[26] = mk(4'h3, 2'b11, 0, 0, 4'h2, 4'h0, 4'h2, 0, 32'h000);
    tbl[27] = mk(4'h3, 2'b11, 0, 0, 4'h0, 4'h0, 4'h0, 1, 32'h100);
    tbl[28] = mk(4'h1, 2'b11, 0, 1, 4'h0, 4'h0, 4'h0, 0, 32'h100);
    tbl[29] = mk(4'h1, 2'b11, 0, 0, 4'h0, 4'h0, 4'h0, 0, 32'h100);
    tbl[30] = mk(4'h1, 2'b11, 0, 0, 4'h0, 4'h0, 4'h0, 0, 32'h100);
    tbl[31] = mk(4'h1, 2'b11, 0, 0, 4'h0, 4'h0, 4'h0, 0, 32'h100);
    tbl[32] = mk(4'h1, 2'b11, 0, 0, 4'h0, 4'h2, 4'h2, 0, 32'h100);
    tbl[33] = mk(4'h1, 2'b11, 0, 0, 4'h0, 4'h0, 4'h0, 1, 32'h200);
    tbl[34] = mk(4'h1, 2'b11, 0, 1, 4'h0, 4'h0, 4'h0, 0, 32'h200);

    // Reset with ch0 already high
    iRst = 1'b1; iHit = 4'b0001; iMode = 2'b01; iClear = 1'b0; iAck = 1'b0;
    clear_seen();
    repeat (3) tick();
    chk("rst_rise", oRise, 0);
    chk("rst_fall", oFall, 0);
    chk("rst_event", oEvent, 0);
    chk("rst_count", oCount, 0);
    chk("rst_valid", oStampValid, 0);
    chk("rst_stamp", oStamp, 0);
    chk("rst_mask", oStampMask, 0);
    chk("rst_ovf", oOverflow, 0);

    iRst = 1'b0;
    clear_seen();
    repeat (12) tick();
    chk("warm_rise0", rise_seen[0], 0);
    chk("warm_events", ev_seen, 0);
    chk("warm_count", oCount, 0);
    chk("warm_valid", oStampValid, 0);

    // Drop ch0 with events disabled
    iMode = 2'b00; iHit = 4'b0000;
    clear_seen();
    repeat (8) tick();
    chk("quiet_fall0", fall_seen[0], 1);
    chk("quiet_events", ev_seen, 0);
    chk("quiet_count", oCount, 0);

    // Cycle-by-cycle table: rise on ch0, mode 10 / mode 11 pulses on ch1
    exp_stamp = 16'd0; exp_mask = 4'd0;
    for (int r = 0; r < 35; r++) begin
      iHit = tbl[r].hit; iMode = tbl[r].mode; iClear = tbl[r].clr; iAck = tbl[r].ack;
      tick();
      chk($sformatf("row%0d_rise", r), oRise, tbl[r].e_rise);
      chk($sformatf("row%0d_fall", r), oFall, tbl[r].e_fall);
      chk($sformatf("row%0d_event", r), oEvent, tbl[r].e_ev);
      chk($sformatf("row%0d_valid", r), oStampValid, tbl[r].e_val);
      chk($sformatf("row%0d_count", r), oCount, tbl[r].e_cnt);
      if (tbl[r].e_ev != 4'b0) begin
        exp_stamp = ts;
        exp_mask  = tbl[r].e_ev;
      end
      if (tbl[r].e_val) begin
        chk($sformatf("row%0d_stamp", r), oStamp, exp_stamp);
        chk($sformatf("row%0d_mask", r), oStampMask, exp_mask);
      end
    end
    iClear = 1'b0; iAck = 1'b0;
    chk("table_ovf", oOverflow, 0);

    // Glitch rejection and 3-cycle pulse on ch2
    iMode = 2'b00;
    clear_seen();
    iHit = 4'b0101; tick();
    iHit = 4'b0001; repeat (8) tick();
    chk("glitch_rise2", rise_seen[2], 0);
    chk("glitch_fall2", fall_seen[2], 0);
    clear_seen();
    iHit = 4'b0101; repeat (3) tick();
    iHit = 4'b0001; repeat (10) tick();
    chk("pulse3_rise2", rise_seen[2], 1);
    chk("pulse3_fall2", fall_seen[2], 1);
    chk("pulse3_spacing", fall_t - rise_t, 3);

    // Overflow while a stamp is held
    iMode = 2'b11;
    iHit = 4'b1001; repeat (5) tick();
    chk("ovf_rise_event", oEvent, 4'b1000);
    s1 = ts;
    tick();
    chk("ovf_cap_valid", oStampValid, 1);
    chk("ovf_cap_stamp", oStamp, s1);
    chk("ovf_cap_mask", oStampMask, 4'b1000);
    chk("ovf_cap_flag", oOverflow, 0);
    iHit = 4'b0001; repeat (5) tick();
    chk("ovf_fall_event", oEvent, 4'b1000);
    tick();
    chk("ovf_flag", oOverflow, 1);
    chk("ovf_stamp_held", oStamp, s1);
    chk("ovf_mask_held", oStampMask, 4'b1000);
    chk("ovf_valid_held", oStampValid, 1);

    // Ack in the same cycle as a new event on ch0
    iHit = 4'b0000; repeat (5) tick();
    chk("ackev_event", oEvent, 4'b0001);
    s2 = ts;
    iAck = 1'b1; tick(); iAck = 1'b0;
    chk("ackev_valid", oStampValid, 1);
    chk("ackev_stamp", oStamp, s2);
    chk("ackev_mask", oStampMask, 4'b0001);
    chk("ackev_ovf", oOverflow, 1);
    iAck = 1'b1; tick(); iAck = 1'b0;
    chk("ack_drop_valid", oStampValid, 0);
    iClear = 1'b1; tick(); iClear = 1'b0;
    chk("clear_ovf", oOverflow, 0);
    chk("clear_count", oCount, 0);

    // Counter saturation on ch0
    for (int n = 0; n < 10; n++) begin iHit[0] = ~iHit[0]; repeat (3) tick(); end
    repeat (6) tick();
    chk("cnt0_10", oCount[7:0], 8'd10);
    for (int n = 0; n < 290; n++) begin iHit[0] = ~iHit[0]; repeat (3) tick(); end
    repeat (6) tick();
    chk("cnt0_sat", oCount[7:0], 8'd255);
    chk("cnt_others", oCount[31:8], 24'd0);

    // Clear in the same cycle as an event
    iHit[0] = 1'b1; repeat (5) tick();
    chk("clrev_event", oEvent, 4'b0001);
    iClear = 1'b1; tick(); iClear = 1'b0;
    chk("clrev_count", oCount[7:0], 8'd0);
    tick();
    chk("clrev_count_hold", oCount[7:0], 8'd0);

    // Timestamp wrap: place an event exactly on the 65535 -> 0 rollover
    iAck = 1'b1; tick(); iAck = 1'b0;
    chk("wrap_pre_valid", oStampValid, 0);
    begin
      int guard;
      guard = 0;
      while (ts != 16'd65531 && guard < 70000) begin tick(); guard++; end
      chk("wrap_reach_budget", guard < 70000, 1);
    end
    iHit[0] = 1'b0; repeat (5) tick();
    chk("wrap_event", oEvent, 4'b0001);
    tick();
    chk("wrap_valid", oStampValid, 1);
    chk("wrap_stamp", oStamp, 16'h0000);

    // Reset mid-operation drops the held stamp
    iRst = 1'b1; tick(); iRst = 1'b0;
    chk("midrst_valid", oStampValid, 0);
    chk("midrst_stamp", oStamp, 0);
    chk("midrst_count", oCount, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
